stream_demux: RTL

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_pkg.sv | 11 +
 rtl/stream_demux_slot.sv | 37 +++
 rtl/stream_demux.sv | 100 ++++++++++
 3 files changed

// File: rtl/stream_demux_pkg.sv
// Shared constants for the stream demultiplexer.
// Counter width and default geometry live here.
package stream_demux_pkg;

  localparam int CNT_W      = 16;
  localparam int DATA_W_DEF = 8;
  localparam int N_OUT_DEF  = 4;
  localparam int N_OUT_MIN  = 2;
  localparam int N_OUT_MAX  = 16;

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel register: data plus valid flag.
// Push wins over pop so a same-cycle refill never bubbles.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);

  // Valid tracks occupancy; push refills, pop alone empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  // Data only moves on push, so it is stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (push) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to N_OUT single-slot channels by in_sel.
// STREAM_DEMUX_CNT_EN adds per-channel delivered-word counters on cnt.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int N_OUT  = N_OUT_DEF,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [N_OUT-1:0]         out_valid,
  input  logic [N_OUT-1:0]         out_ready,
  output logic [N_OUT*DATA_W-1:0]  out_data,
  output logic                     drop
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0]   cnt
`endif
);

  if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_n
    $error("stream_demux: N_OUT out of range");
  end

  logic [SEL_W:0]   sel_x;
  logic             bad;
  logic             acc;
  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] room;
  logic [N_OUT-1:0] push;
  logic [N_OUT-1:0] pop;
  logic [N_OUT-1:0] vld;

  // Decode the destination; out-of-range indices are always accepted.
  always_comb begin
    sel_x = {1'b0, in_sel};
    bad   = sel_x >= (SEL_W+1)'(N_OUT);
    hit   = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = sel_x == (SEL_W+1)'(k);
    end
  end

  // Handshake: a slot has room if empty or draining this cycle.
  always_comb begin
    pop      = vld & out_ready;
    room     = ~vld | out_ready;
    in_ready = bad | (|(hit & room));
    acc      = in_valid & in_ready;
    push     = hit & {N_OUT{acc}};
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   (in_data),
      .valid (vld[k]),
      .dout  (out_data[k*DATA_W +: DATA_W])
    );
  end

  assign out_valid = vld;

  // One-cycle pulse for each discarded out-of-range word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else begin
      drop <= in_valid & bad;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Count delivered words; natural wrap at the top.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (pop[k]) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign cnt[k*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule
